mc_control_fsm: RTL

- Multi-cycle RV32I control unit: a Moore state machine sequencing each instruction through fetch, decode, execute, memory and write-back states.
- Drives every datapath enable and mux select, including the register file's `write_enable` (RegWrite) and `is_ecall`.
- Consumes the latched instruction opcode, the ALU branch condition and the register file's `is_halted`.
- Sits directly upstream of the register file, between the instruction register and the datapath.

---
 rtl/mc_control_fsm.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle RV32I control unit. A Moore state machine steps
//               each instruction through IF, ID, EX, MEM and WB states and
//               drives every datapath enable and mux select.
//               Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN
//                 defined   -> unrecognised opcode in ID halts the FSM
//                 undefined -> unrecognised opcode in ID is a 2-cycle NOP
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       is_halted,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       is_ecall,
  output logic [3:0] state
);

  // --------------------------------------------------------------------------
  // State encoding (12..14 unused)
  // --------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_EX_BR   = 4'd9,
    S_EX_JAL  = 4'd10,
    S_EX_JALR = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  // Bundle of every Moore control output, registered together.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
  } ctrl_t;

  // Opcodes
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  // Mux select encodings
  localparam logic [1:0] c_SRCA_PC    = 2'b00;
  localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] c_SRCA_REG   = 2'b10;
  localparam logic [1:0] c_SRCB_REG   = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] c_SRCB_IMM   = 2'b10;
  localparam logic [1:0] c_ALU_ADD    = 2'b00;
  localparam logic [1:0] c_ALU_BRANCH = 2'b01;
  localparam logic [1:0] c_ALU_FUNCT  = 2'b10;
  localparam logic [1:0] c_RD_ALUOUT  = 2'b00;
  localparam logic [1:0] c_RD_MDR     = 2'b01;
  localparam logic [1:0] c_RD_PC      = 2'b10;

  localparam ctrl_t c_CTRL_NONE = '0;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_o;

  // The ALU branch condition gates the PC inside the datapath through
  // pc_write_cond; the sequencing itself never depends on it.
  logic unused_bcond;
  assign unused_bcond = alu_bcond;

  // Per-state Moore output table; anything not set stays 0.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = c_CTRL_NONE;
    case (s)
      S_IF: begin
        // Fetch and PC <- PC + 4 in the same cycle
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_a = c_SRCA_PC;
        c.alu_src_b = c_SRCB_FOUR;
        c.alu_op    = c_ALU_ADD;
        c.pc_write  = 1'b1;
        c.pc_source = 1'b0;
      end
      S_ID: begin
        // Speculative branch/jump target: ALUOut <- old_pc + imm
        c.alu_src_a = c_SRCA_OLDPC;
        c.alu_src_b = c_SRCB_IMM;
        c.alu_op    = c_ALU_ADD;
      end
      S_EX_R: begin
        c.alu_src_a = c_SRCA_REG;
        c.alu_src_b = c_SRCB_REG;
        c.alu_op    = c_ALU_FUNCT;
      end
      S_EX_I: begin
        c.alu_src_a = c_SRCA_REG;
        c.alu_src_b = c_SRCB_IMM;
        c.alu_op    = c_ALU_FUNCT;
      end
      S_EX_ADDR: begin
        c.alu_src_a = c_SRCA_REG;
        c.alu_src_b = c_SRCB_IMM;
        c.alu_op    = c_ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_WB_ALU: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = c_RD_ALUOUT;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = c_RD_MDR;
      end
      S_EX_BR: begin
        // Compare rs1/rs2; target already sits in ALUOut from ID
        c.alu_src_a     = c_SRCA_REG;
        c.alu_src_b     = c_SRCB_REG;
        c.alu_op        = c_ALU_BRANCH;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      S_EX_JAL: begin
        // PC was incremented in IF, so the PC mux yields old_pc + 4 for rd
        c.reg_write  = 1'b1;
        c.mem_to_reg = c_RD_PC;
        c.pc_write   = 1'b1;
        c.pc_source  = 1'b1;
      end
      S_EX_JALR: begin
        // Target rs1 + imm straight from the ALU; datapath clears bit 0
        c.reg_write  = 1'b1;
        c.mem_to_reg = c_RD_PC;
        c.alu_src_a  = c_SRCA_REG;
        c.alu_src_b  = c_SRCB_IMM;
        c.alu_op     = c_ALU_ADD;
        c.pc_write   = 1'b1;
        c.pc_source  = 1'b0;
      end
      default: c = c_CTRL_NONE;
    endcase
    return c;
  endfunction

  // Next-state selection from the current state, opcode and halt flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:      state_d = is_halted ? S_HALT : S_ID;
      S_ID: begin
        case (opcode)
          c_OP_RTYPE:  state_d = S_EX_R;
          c_OP_ITYPE:  state_d = S_EX_I;
          c_OP_LOAD:   state_d = S_EX_ADDR;
          c_OP_STORE:  state_d = S_EX_ADDR;
          c_OP_BRANCH: state_d = S_EX_BR;
          c_OP_JAL:    state_d = S_EX_JAL;
          c_OP_JALR:   state_d = S_EX_JALR;
          c_OP_SYSTEM: state_d = S_IF;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_IF;
`endif
          end
        endcase
      end
      S_EX_R:    state_d = S_WB_ALU;
      S_EX_I:    state_d = S_WB_ALU;
      S_EX_ADDR: state_d = (opcode == c_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_WB_MEM;
      S_MEM_WR:  state_d = S_IF;
      S_WB_ALU:  state_d = S_IF;
      S_WB_MEM:  state_d = S_IF;
      S_EX_BR:   state_d = S_IF;
      S_EX_JAL:  state_d = S_IF;
      S_EX_JALR: state_d = S_IF;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IF;
    endcase
  end

  // State register; outputs are pre-decoded from the next state so they
  // line up with state_q in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      ctrl_q  <= ctrl_decode(S_IF);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  // Reset kills every control output immediately so an aborted instruction
  // cannot issue a write in the aborting cycle.
  assign ctrl_o = reset ? c_CTRL_NONE : ctrl_q;

  assign pc_write      = ctrl_o.pc_write;
  assign pc_write_cond = ctrl_o.pc_write_cond;
  assign i_or_d        = ctrl_o.i_or_d;
  assign mem_read      = ctrl_o.mem_read;
  assign mem_write     = ctrl_o.mem_write;
  assign ir_write      = ctrl_o.ir_write;
  assign mem_to_reg    = ctrl_o.mem_to_reg;
  assign reg_write     = ctrl_o.reg_write;
  assign alu_src_a     = ctrl_o.alu_src_a;
  assign alu_src_b     = ctrl_o.alu_src_b;
  assign alu_op        = ctrl_o.alu_op;
  assign pc_source     = ctrl_o.pc_source;

  // ECALL strobe is the single Mealy-style output: ID state plus opcode.
  assign is_ecall = ~reset && (state_q == S_ID) && (opcode == c_OP_SYSTEM);

  assign state = state_q;

endmodule
`default_nettype wire
